// File: rtl/circuit_vector_sequencer.sv
// Exhaustive stimulus sequencer: walks every input vector of a small combinational
// circuit, captures its truth table and scores it against a golden table.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start_i; vec_out_o=0, results from last sweep held
// S_DRIVE | vec_out_o=idx held HOLD_CYCLES cycles, sampled on the last one
// S_DONE  | one-cycle done_o pulse, then back to S_IDLE
module circuit_vector_sequencer #(
   parameter int N_IN        = 3,
   parameter int N_OUT       = 2,
   parameter int HOLD_CYCLES = 20
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start_i,
   input  logic                          abort_i,
   input  logic [(2**N_IN)*N_OUT-1:0]    exp_table_i,
   input  logic [N_OUT-1:0]              resp_in_i,
   output logic [N_IN-1:0]               vec_out_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic [(2**N_IN)*N_OUT-1:0]    table_out_o,
   output logic [N_IN:0]                 mismatch_cnt_o,
   output logic                          fail_o,
   output logic [N_IN-1:0]               first_fail_idx_o
);

   localparam int NVEC = 2**N_IN;
   localparam int TW   = NVEC*N_OUT;
   localparam int HW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES-1);
   localparam logic [N_IN-1:0] IDX_LAST  = N_IN'(NVEC-1);

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [N_IN-1:0]   idx_q, idx_d;
   logic [HW-1:0]     hold_q, hold_d;
   logic [N_IN-1:0]   vec_q, vec_d;
   logic [TW-1:0]     table_q, table_d;
   logic [N_IN:0]     mcnt_q, mcnt_d;
   logic              fail_q, fail_d;
   logic [N_IN-1:0]   ffi_q, ffi_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         hold_q  <= '0;
         vec_q   <= '0;
         table_q <= '0;
         mcnt_q  <= '0;
         fail_q  <= 1'b0;
         ffi_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         vec_q   <= vec_d;
         table_q <= table_d;
         mcnt_q  <= mcnt_d;
         fail_q  <= fail_d;
         ffi_q   <= ffi_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      vec_d   = vec_q;
      table_d = table_q;
      mcnt_d  = mcnt_q;
      fail_d  = fail_q;
      ffi_d   = ffi_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_DRIVE;
               idx_d   = '0;
               hold_d  = '0;
               vec_d   = '0;
               table_d = '0;
               mcnt_d  = '0;
               fail_d  = 1'b0;
               ffi_d   = '0;
            end
         end
         S_DRIVE: begin
            if (hold_q == HOLD_LAST) begin
               table_d[idx_q*N_OUT +: N_OUT] = resp_in_i;
               if (resp_in_i != exp_table_i[idx_q*N_OUT +: N_OUT]) begin
                  mcnt_d = mcnt_q + 1'b1;
                  if (!fail_q) begin
                     fail_d = 1'b1;
                     ffi_d  = idx_q;
                  end
               end
               hold_d = '0;
               if (idx_q == IDX_LAST) begin
                  state_d = S_DONE;
                  vec_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
                  vec_d = idx_q + 1'b1;
               end
            end else begin
               hold_d = hold_q + 1'b1;
            end
            // Abort overrides the end-of-sweep transition but keeps the sample above.
            if (abort_i) begin
               state_d = S_IDLE;
               vec_d   = '0;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign vec_out_o        = vec_q;
   assign busy_o           = (state_q == S_DRIVE);
   assign done_o           = (state_q == S_DONE);
   assign table_out_o      = table_q;
   assign mismatch_cnt_o   = mcnt_q;
   assign fail_o           = fail_q;
   assign first_fail_idx_o = ffi_q;

endmodule

// File: tb/tb_circuit_vector_sequencer.sv
// Directed bench for circuit_vector_sequencer: N_IN=3, N_OUT=2, HOLD_CYCLES=4 (and 1),
// with the circuit under test modelled as resp = vec[1:0].
module tb_circuit_vector_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] exp_tab = 16'h0000;
   logic [1:0]  resp;
   logic [2:0]  vec;
   logic        busy, done, fail;
   logic [15:0] tab;
   logic [3:0]  mcnt;
   logic [2:0]  ffi;

   logic        s1_start = 1'b0;
   logic [1:0]  s1_resp;
   logic [2:0]  s1_vec;
   logic        s1_busy, s1_done, s1_fail;
   logic [15:0] s1_tab;
   logic [3:0]  s1_mcnt;
   logic [2:0]  s1_ffi;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   assign resp    = vec[1:0];
   assign s1_resp = s1_vec[1:0];

   circuit_vector_sequencer #(.N_IN(3), .N_OUT(2), .HOLD_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
      .exp_table_i(exp_tab), .resp_in_i(resp), .vec_out_o(vec), .busy_o(busy),
      .done_o(done), .table_out_o(tab), .mismatch_cnt_o(mcnt), .fail_o(fail),
      .first_fail_idx_o(ffi));

   circuit_vector_sequencer #(.N_IN(3), .N_OUT(2), .HOLD_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start_i(s1_start), .abort_i(1'b0),
      .exp_table_i(16'hE4E4), .resp_in_i(s1_resp), .vec_out_o(s1_vec), .busy_o(s1_busy),
      .done_o(s1_done), .table_out_o(s1_tab), .mismatch_cnt_o(s1_mcnt), .fail_o(s1_fail),
      .first_fail_idx_o(s1_ffi));

   // Start is sampled on edge k; returns 1ns after edge k.
   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Observes ncyc edges after start for a HOLD_CYCLES=4 sweep; optionally raises
   // start (ignored by the DUT) after two chosen edges. Counts vec/busy deviations.
   task automatic watch(input int ncyc, input int st_a, input int st_b,
                        output int done_cnt, output int done_at, output int seq_bad);
      int ev;
      done_cnt = 0; done_at = -1; seq_bad = 0;
      for (int c = 1; c <= ncyc; c++) begin
         @(posedge clk);
         #1;
         ev = (c < 32) ? c / 4 : 0;
         if (vec !== 3'(ev)) seq_bad++;
         if (busy !== (c < 32)) seq_bad++;
         if (done === 1'b1) begin
            done_cnt++;
            done_at = c;
         end
         start = (c == st_a || c == st_b);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      tests_run++;
      if ({vec, busy, done, tab, mcnt, fail, ffi} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs got %h required 0", {vec, busy, done, tab, mcnt, fail, ffi});
      end
      #14 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if ({vec, busy, done} !== 5'd0) begin
         tests_failed++;
         $display("FAIL idle_after_reset got %b required 00000", {vec, busy, done});
      end
   endtask

   task automatic test_clean_sweep();
      int dc, da, sb;
      exp_tab = 16'hE4E4;
      pulse_start();
      tests_run++;
      if (busy !== 1'b1 || vec !== 3'd0) begin
         tests_failed++;
         $display("FAIL clean_start got busy=%b vec=%0d required busy=1 vec=0", busy, vec);
      end
      watch(40, -1, -1, dc, da, sb);
      tests_run++;
      if (sb !== 0) begin
         tests_failed++;
         $display("FAIL clean_sequence got %0d deviations required 0", sb);
      end
      tests_run++;
      if (dc !== 1 || da !== 32) begin
         tests_failed++;
         $display("FAIL clean_done got count=%0d at=%0d required count=1 at=32", dc, da);
      end
      tests_run++;
      if (tab !== 16'hE4E4 || mcnt !== 4'd0 || fail !== 1'b0 || ffi !== 3'd0) begin
         tests_failed++;
         $display("FAIL clean_results got tab=%h cnt=%0d fail=%b ffi=%0d required E4E4/0/0/0",
                  tab, mcnt, fail, ffi);
      end
   endtask

   task automatic test_mismatch();
      int dc, da, sb;
      exp_tab = 16'hE0E4;
      pulse_start();
      watch(34, -1, -1, dc, da, sb);
      tests_run++;
      if (tab !== 16'hE4E4 || mcnt !== 4'd1 || fail !== 1'b1 || ffi !== 3'd5) begin
         tests_failed++;
         $display("FAIL single_mismatch got tab=%h cnt=%0d fail=%b ffi=%0d required E4E4/1/1/5",
                  tab, mcnt, fail, ffi);
      end
      // Entries 6 and 7 expected 00, actual 10 and 11.
      exp_tab = 16'h04E4;
      pulse_start();
      tests_run++;
      if (tab !== 16'h0000 || mcnt !== 4'd0 || fail !== 1'b0 || ffi !== 3'd0) begin
         tests_failed++;
         $display("FAIL clear_on_start got tab=%h cnt=%0d fail=%b ffi=%0d required 0/0/0/0",
                  tab, mcnt, fail, ffi);
      end
      watch(34, -1, -1, dc, da, sb);
      tests_run++;
      if (mcnt !== 4'd2 || fail !== 1'b1 || ffi !== 3'd6 || dc !== 1) begin
         tests_failed++;
         $display("FAIL double_mismatch got cnt=%0d fail=%b ffi=%0d done=%0d required 2/1/6/1",
                  mcnt, fail, ffi, dc);
      end
   endtask

   task automatic test_busy_done_rules();
      int dc, da, sb;
      exp_tab = 16'hE4E4;
      pulse_start();
      watch(44, 10, 32, dc, da, sb);
      tests_run++;
      if (sb !== 0 || dc !== 1 || da !== 32) begin
         tests_failed++;
         $display("FAIL start_ignored got dev=%0d done=%0d at=%0d required 0/1/32", sb, dc, da);
      end
   endtask

   task automatic test_abort();
      int dc, da, sb;
      exp_tab = 16'hE4E4;
      pulse_start();
      repeat (9) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      tests_run++;
      if (busy !== 1'b0 || vec !== 3'd0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_idle got busy=%b vec=%0d done=%b required 0/0/0", busy, vec, done);
      end
      tests_run++;
      if (tab !== 16'h0004 || mcnt !== 4'd0 || fail !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_partial got tab=%h cnt=%0d fail=%b required 0004/0/0", tab, mcnt, fail);
      end
      dc = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1 || busy === 1'b1) dc++;
      end
      tests_run++;
      if (dc !== 0) begin
         tests_failed++;
         $display("FAIL abort_quiet got %0d active cycles required 0", dc);
      end
      pulse_start();
      watch(34, -1, -1, dc, da, sb);
      tests_run++;
      if (sb !== 0 || dc !== 1 || tab !== 16'hE4E4) begin
         tests_failed++;
         $display("FAIL post_abort_sweep got dev=%0d done=%0d tab=%h required 0/1/E4E4", sb, dc, tab);
      end
   endtask

   task automatic test_abort_on_last();
      exp_tab = 16'hE0E4;
      pulse_start();
      repeat (31) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0 || tab !== 16'hE4E4 || mcnt !== 4'd1 || ffi !== 3'd5) begin
         tests_failed++;
         $display("FAIL abort_last got done=%b busy=%b tab=%h cnt=%0d ffi=%0d required 0/0/E4E4/1/5",
                  done, busy, tab, mcnt, ffi);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (done !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_last_nodone got done=%b required 0", done);
      end
   endtask

   task automatic test_async_reset();
      int dc, da, sb;
      exp_tab = 16'hE4E4;
      pulse_start();
      repeat (16) @(posedge clk);
      #3;
      tests_run++;
      if (vec !== 3'd4 || tab !== 16'h00E4) begin
         tests_failed++;
         $display("FAIL pre_reset got vec=%0d tab=%h required 4/00E4", vec, tab);
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({vec, busy, done, tab, mcnt, fail, ffi} !== '0) begin
         tests_failed++;
         $display("FAIL async_reset got %h required 0", {vec, busy, done, tab, mcnt, fail, ffi});
      end
      @(negedge clk);
      rst_n = 1'b1;
      dc = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1 || busy === 1'b1) dc++;
      end
      tests_run++;
      if (dc !== 0) begin
         tests_failed++;
         $display("FAIL reset_quiet got %0d active cycles required 0", dc);
      end
      pulse_start();
      watch(34, -1, -1, dc, da, sb);
      tests_run++;
      if (sb !== 0 || dc !== 1 || da !== 32 || tab !== 16'hE4E4) begin
         tests_failed++;
         $display("FAIL post_reset_sweep got dev=%0d done=%0d at=%0d tab=%h required 0/1/32/E4E4",
                  sb, dc, da, tab);
      end
   endtask

   task automatic test_hold_one();
      int dc, da, bad;
      @(negedge clk);
      s1_start = 1'b1;
      @(posedge clk);
      #1;
      s1_start = 1'b0;
      dc = 0; da = -1; bad = 0;
      if (s1_busy !== 1'b1 || s1_vec !== 3'd0) bad++;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk);
         #1;
         if (s1_vec !== ((c < 8) ? 3'(c) : 3'd0)) bad++;
         if (s1_done === 1'b1) begin
            dc++;
            da = c;
         end
      end
      tests_run++;
      if (bad !== 0 || dc !== 1 || da !== 8) begin
         tests_failed++;
         $display("FAIL hold1_timing got dev=%0d done=%0d at=%0d required 0/1/8", bad, dc, da);
      end
      tests_run++;
      if (s1_tab !== 16'hE4E4 || s1_mcnt !== 4'd0 || s1_fail !== 1'b0 || s1_ffi !== 3'd0) begin
         tests_failed++;
         $display("FAIL hold1_results got tab=%h cnt=%0d fail=%b ffi=%0d required E4E4/0/0/0",
                  s1_tab, s1_mcnt, s1_fail, s1_ffi);
      end
   endtask

   initial begin
      test_reset();
      test_clean_sweep();
      test_mismatch();
      test_busy_done_rules();
      test_abort();
      test_abort_on_last();
      test_async_reset();
      test_hold_one();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
